sdram_port_arbiter: RTL and testbench

Parametrised N-port arbiter placed between the SDRAM controller's single command interface and its requesters: the flash loader, the 6502 CPU-bus bridge, the 2C02 PPU-bus bridge, and future mappers. It replaces the two-way `read_flash_over` address/valid mux with per-port request/acknowledge handshakes. It supports round-robin or fixed-priority arbitration, per-port enable masking, and routes each read response back to the port that issued it.

---
 rtl/sdram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: N-port request/ack arbiter in front of the SDRAM
// controller command interface, routing read data back to the issuer.
module sdram_port_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_en,
  input  logic [NUM_PORTS-1:0]            p_req,
  input  logic [NUM_PORTS-1:0]            p_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]            p_ack,
  output logic [NUM_PORTS-1:0]            p_rvalid,
  output logic [DATA_WIDTH-1:0]           p_rdata,
  output logic [ADDR_WIDTH-1:0]           sd_addr,
  output logic                            sd_rw,
  output logic [DATA_WIDTH-1:0]           sd_data_in,
  output logic                            sd_in_valid,
  input  logic                            sd_busy,
  input  logic [DATA_WIDTH-1:0]           sd_data_out,
  input  logic                            sd_out_valid
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, GAP, WAIT_RD} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic                   rw_q, rw_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   sdrw_q, sdrw_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   iv_q, iv_d;

  logic [ADDR_WIDTH-1:0]  addr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];
  logic [NUM_PORTS-1:0]   elig;
  logic                   found;
  logic [PW-1:0]          win;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_a[g]  = p_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = p_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign elig = p_req & port_en;

  // Winner: first eligible port at/after the pointer (RR) or lowest index.
  always_comb begin
    int            k;
    logic [PW-1:0] kk;
    found = 1'b0;
    win   = '0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = (RR_MODE != 0) ? int'(ptr_q) + i : i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      kk = PW'(k);
      if (!found && elig[kk]) begin
        found = 1'b1;
        win   = kk;
      end
    end
  end

  // Next state and registered outputs; pulses default low each cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    rw_d     = rw_q;
    ack_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    sdrw_d   = sdrw_q;
    din_d    = din_q;
    iv_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sd_busy && found) begin
          addr_d     = addr_a[win];
          sdrw_d     = p_rw[win];
          din_d      = wdata_a[win];
          iv_d       = 1'b1;
          ack_d[win] = 1'b1;
          owner_d    = win;
          rw_d       = p_rw[win];
          if (win == PW'(NUM_PORTS - 1)) ptr_d = '0;
          else                           ptr_d = win + 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = rw_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (sd_out_valid) begin
          rdata_d           = sd_data_out;
          rvalid_d[owner_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      rw_q     <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      sdrw_q   <= 1'b0;
      din_q    <= '0;
      iv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      sdrw_q   <= sdrw_d;
      din_q    <= din_d;
      iv_q     <= iv_d;
    end
  end

  assign p_ack       = ack_q;
  assign p_rvalid    = rvalid_q;
  assign p_rdata     = rdata_q;
  assign sd_addr     = addr_q;
  assign sd_rw       = sdrw_q;
  assign sd_data_in  = din_q;
  assign sd_in_valid = iv_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for the SDRAM port arbiter,
// one round-robin and one fixed-priority instance on shared stimulus.
module tb_sdram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 23;
  localparam int DW = 32;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    port_en, p_req, p_rw;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;
  logic            sd_busy, sd_out_valid;
  logic [DW-1:0]   sd_data_out;

  logic [N-1:0]    ack_a, rv_a, ack_b, rv_b;
  logic [DW-1:0]   rdata_a, din_a, rdata_b, din_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic            rw_a, iv_a, rw_b, iv_b;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .p_req(p_req),
    .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(ack_a), .p_rvalid(rv_a), .p_rdata(rdata_a),
    .sd_addr(addr_a), .sd_rw(rw_a), .sd_data_in(din_a),
    .sd_in_valid(iv_a), .sd_busy(sd_busy),
    .sd_data_out(sd_data_out), .sd_out_valid(sd_out_valid)
  );

  sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .p_req(p_req),
    .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(ack_b), .p_rvalid(rv_b), .p_rdata(rdata_b),
    .sd_addr(addr_b), .sd_rw(rw_b), .sd_data_in(din_b),
    .sd_in_valid(iv_b), .sd_busy(sd_busy),
    .sd_data_out(sd_data_out), .sd_out_valid(sd_out_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic rw,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_rw[k]            = rw;
    p_addr[k*AW +: AW] = a;
    p_wdata[k*DW +: DW] = d;
  endtask

  task automatic push_exp(input int k);
    exp_q.push_back('{k, p_addr[k*AW +: AW], p_rw[k], p_wdata[k*DW +: DW]});
  endtask

  task automatic wait_iv(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((use_b ? iv_b : iv_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_req = '0;
    sd_busy = 1'b0;
    sd_out_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    port_en = '1;
    p_req = '0;
    p_rw = '0;
    p_addr = '0;
    p_wdata = '0;
    sd_busy = 1'b0;
    sd_out_valid = 1'b0;
    sd_data_out = '0;
    tick();
    tick();
    checks++;
    if ({ack_a, rv_a, iv_a, rw_a, addr_a, din_a, rdata_a} !== '0) begin
      errors++;
      $display("FAIL reset_rr: ack=%b rv=%b iv=%b rw=%b addr=%h din=%h rd=%h, required all 0",
               ack_a, rv_a, iv_a, rw_a, addr_a, din_a, rdata_a);
    end
    checks++;
    if ({ack_b, rv_b, iv_b, rw_b, addr_b, din_b, rdata_b} !== '0) begin
      errors++;
      $display("FAIL reset_fp: ack=%b rv=%b iv=%b rw=%b addr=%h din=%h rd=%h, required all 0",
               ack_b, rv_b, iv_b, rw_b, addr_b, din_b, rdata_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bit ok;
    int bad;
    do_reset();
    port_en = '1;
    set_port(1, 1'b0, 23'h000123, 32'h1111_2222);
    push_exp(1);
    p_req = 3'b010;
    wait_iv(1'b0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_a !== (3'b001 << e.port) || addr_a !== e.addr ||
        rw_a !== e.rw || din_a !== e.data) begin
      errors++;
      $display("FAIL single_grant: ok=%0b ack=%b addr=%h rw=%b din=%h, required ack=%b addr=%h rw=%b din=%h",
               ok, ack_a, addr_a, rw_a, din_a, 3'b001 << e.port, e.addr, e.rw, e.data);
    end
    p_req = '0;
    sd_busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_a !== '0 || rv_a !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_quiet: %0d cycles with ack/rvalid high, required 0", bad);
    end
    sd_out_valid = 1'b1;
    sd_data_out = 32'hDEAD_BEEF;
    sd_busy = 1'b0;
    tick();
    sd_out_valid = 1'b0;
    checks++;
    if (rv_a !== 3'b010 || rdata_a !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rvalid: rv=%b rdata=%h, required rv=010 rdata=deadbeef",
               rv_a, rdata_a);
    end
    tick();
    checks++;
    if (rv_a !== '0) begin
      errors++;
      $display("FAIL single_rvalid_pulse: rv=%b, required 000", rv_a);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    port_en = '1;
    for (int k = 0; k < N; k++)
      set_port(k, 1'b1, AW'(23'h000400 + k), 32'hA0A0_0000 + k);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_exp(k);
    p_req = '1;
    for (int g = 0; g < 2 * N; g++) begin
      wait_iv(1'b0, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || ack_a !== (3'b001 << e.port) || addr_a !== e.addr ||
          rw_a !== 1'b1 || din_a !== e.data) begin
        errors++;
        $display("FAIL rr_grant%0d: ok=%0b ack=%b addr=%h rw=%b din=%h, required ack=%b addr=%h rw=1 din=%h",
                 g, ok, ack_a, addr_a, rw_a, din_a, 3'b001 << e.port, e.addr, e.data);
      end
      sd_busy = 1'b1;
      repeat (4) tick();
      sd_busy = 1'b0;
    end
    p_req = '0;
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    bit ok;
    do_reset();
    port_en = '1;
    set_port(0, 1'b1, 23'h000500, 32'hF000_0000);
    set_port(2, 1'b1, 23'h000502, 32'hF000_0002);
    p_req = 3'b101;
    for (int g = 0; g < 4; g++) begin
      push_exp(g < 3 ? 0 : 2);
      wait_iv(1'b1, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || ack_b !== (3'b001 << e.port) || addr_b !== e.addr ||
          din_b !== e.data) begin
        errors++;
        $display("FAIL fp_grant%0d: ok=%0b ack=%b addr=%h din=%h, required ack=%b addr=%h din=%h",
                 g, ok, ack_b, addr_b, din_b, 3'b001 << e.port, e.addr, e.data);
      end
      if (g == 2) p_req = 3'b100;
    end
    p_req = '0;
    tick();
    tick();
  endtask

  task automatic test_enable_mask();
    bit ok;
    int cnt;
    do_reset();
    port_en = 3'b110;
    set_port(0, 1'b0, 23'h000600, 32'h0);
    p_req = 3'b001;
    cnt = 0;
    repeat (50) begin
      tick();
      if (iv_a !== 1'b0 || iv_b !== 1'b0 || ack_a !== '0 || ack_b !== '0) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL mask_nogrant: %0d grant cycles, required 0", cnt);
    end
    set_port(1, 1'b0, 23'h000611, 32'h0);
    push_exp(1);
    p_req = 3'b010;
    wait_iv(1'b0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_a !== (3'b001 << e.port) || addr_a !== e.addr ||
        rw_a !== e.rw) begin
      errors++;
      $display("FAIL mask_grant: ok=%0b ack=%b addr=%h rw=%b, required ack=%b addr=%h rw=%b",
               ok, ack_a, addr_a, rw_a, 3'b001 << e.port, e.addr, e.rw);
    end
    p_req = '0;
    sd_busy = 1'b1;
    tick();
    tick();
    port_en = 3'b100;
    tick();
    tick();
    sd_out_valid = 1'b1;
    sd_data_out = 32'hCAFE_F00D;
    sd_busy = 1'b0;
    tick();
    sd_out_valid = 1'b0;
    checks++;
    if (rv_a !== 3'b010 || rdata_a !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mask_inflight_rvalid: rv=%b rdata=%h, required rv=010 rdata=cafef00d",
               rv_a, rdata_a);
    end
    port_en = '1;
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int cnt;
    do_reset();
    port_en = '1;
    set_port(0, 1'b0, 23'h000700, 32'h7070_7070);
    push_exp(0);
    p_req = 3'b001;
    wait_iv(1'b0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_a !== (3'b001 << e.port) || addr_a !== e.addr) begin
      errors++;
      $display("FAIL rst_first_grant: ok=%0b ack=%b addr=%h, required ack=%b addr=%h",
               ok, ack_a, addr_a, 3'b001 << e.port, e.addr);
    end
    p_req = '0;
    sd_busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack_a, rv_a, iv_a, rw_a, addr_a, din_a, rdata_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ack=%b rv=%b iv=%b addr=%h din=%h rd=%h, required all 0",
               ack_a, rv_a, iv_a, addr_a, din_a, rdata_a);
    end
    tick();
    rst_n = 1'b1;
    sd_busy = 1'b0;
    tick();
    sd_out_valid = 1'b1;
    sd_data_out = 32'hBAD0_BAD0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sd_out_valid = 1'b0;
      if (rv_a !== '0) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL rst_no_rvalid: %0d cycles with rvalid, required 0", cnt);
    end
    set_port(0, 1'b1, 23'h000710, 32'h0000_0710);
    set_port(2, 1'b1, 23'h000712, 32'h0000_0712);
    push_exp(0);
    p_req = 3'b101;
    wait_iv(1'b0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || ack_a !== (3'b001 << e.port) || addr_a !== e.addr ||
        din_a !== e.data) begin
      errors++;
      $display("FAIL rst_ptr_zero: ok=%0b ack=%b addr=%h din=%h, required ack=%b addr=%h din=%h",
               ok, ack_a, addr_a, din_a, 3'b001 << e.port, e.addr, e.data);
    end
    p_req = '0;
    tick();
    tick();
  endtask

  task automatic test_busy_backpressure();
    int cnt;
    do_reset();
    port_en = '1;
    for (int k = 0; k < N; k++)
      set_port(k, 1'b1, AW'(23'h000800 + k), 32'hB000_0000 + k);
    sd_busy = 1'b1;
    p_req = '1;
    cnt = 0;
    repeat (20) begin
      tick();
      if (iv_a !== 1'b0 || ack_a !== '0) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d grant cycles while busy, required 0", cnt);
    end
    for (int w = 0; w < N; w++) begin
      push_exp(w);
      sd_busy = 1'b0;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (iv_a !== 1'b1 || ack_a !== (3'b001 << e.port) ||
          addr_a !== e.addr || din_a !== e.data) begin
        errors++;
        $display("FAIL busy_win%0d_grant: iv=%b ack=%b addr=%h din=%h, required iv=1 ack=%b addr=%h din=%h",
                 w, iv_a, ack_a, addr_a, din_a, 3'b001 << e.port, e.addr, e.data);
      end
      cnt = (iv_a === 1'b1) ? 1 : 0;
      tick();
      sd_busy = 1'b1;
      if (iv_a === 1'b1) cnt++;
      repeat (4) begin
        tick();
        if (iv_a === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 1) begin
        errors++;
        $display("FAIL busy_win%0d_count: %0d grants, required 1", w, cnt);
      end
    end
    p_req = '0;
    sd_busy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_enable_mask();
    test_reset_mid_read();
    test_busy_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
